// File: rtl/cost_batch_controller.sv
// cost_batch_controller
//
// Sequences the cost calculator across one training batch of BATCH_SIZE samples.
// Each sample (one-hot expected label plus ten 4-bit confidences) is taken over a
// valid/ready handshake and held stable. The calculator is then launched with a
// one-cycle cost_en pulse. Its result is folded into a saturating batch total and
// a running maximum. The block reports batch completion, calculator timeouts and
// malformed labels.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start                 begin a new batch (honoured only in IDLE or ERROR)
//   sample_valid          sample offered on label_in / weights_in
//   sample_ready          controller can accept a sample (WAIT_SAMPLE only)
//   label_in [9:0]        expected label, one-hot, bit 0 = digit 0
//   weights_in [39:0]     ten 4-bit confidences, [3:0] = digit 0
//   cost_en               one-cycle launch pulse to the calculator
//   expected_label        held label driven to the calculator
//   digit_weights         held confidences driven to the calculator
//   calculation_complete  calculator done pulse; cost_output valid with it
//   cost_output [7:0]     calculator result
//   batch_total           saturating sum of accepted costs
//   batch_max             largest single cost seen in the batch
//   sample_count          samples accumulated so far
//   busy                  high in every state except IDLE and ERROR
//   batch_done            one-cycle pulse when the batch finishes
//   timeout_err           sticky: calculator did not finish within TIMEOUT cycles
//   label_err             sticky: a sample was rejected as not one-hot

module cost_batch_controller #(
    parameter int unsigned BATCH_SIZE = 16,
    parameter int unsigned TIMEOUT    = 80,
    parameter int unsigned ACC_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [9:0]       label_in,
    input  logic [39:0]      weights_in,
    output logic             cost_en,
    output logic [9:0]       expected_label,
    output logic [39:0]      digit_weights,
    input  logic             calculation_complete,
    input  logic [7:0]       cost_output,
    output logic [ACC_W-1:0] batch_total,
    output logic [7:0]       batch_max,
    output logic [4:0]       sample_count,
    output logic             busy,
    output logic             batch_done,
    output logic             timeout_err,
    output logic             label_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = ACC_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSample,
        StLaunch,
        StWaitCalc,
        StAccum,
        StDone,
        StError
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [7:0]      cost_reg;

    // Next-state helpers
    logic [9:0]      label_m1;
    logic            label_onehot;
    logic [SW-1:0]   sum_wide;
    logic [ACC_W-1:0] sat_total;
    logic [4:0]      next_count;

    always_comb begin
        label_m1     = label_in - 10'd1;
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
        label_onehot = (label_in != 10'd0) && ((label_in & label_m1) == 10'd0);
        sum_wide     = {1'b0, batch_total} + SW'(cost_reg);
        // The carry out means the sum overflowed; clamp to all-ones. Once the total is
        // all-ones, any further add also overflows or stays put, so saturation sticks.
        sat_total    = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        next_count   = sample_count + 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            timer          <= '0;
            cost_reg       <= '0;
            sample_ready   <= 1'b0;
            cost_en        <= 1'b0;
            expected_label <= '0;
            digit_weights  <= '0;
            batch_total    <= '0;
            batch_max      <= '0;
            sample_count   <= '0;
            busy           <= 1'b0;
            batch_done     <= 1'b0;
            timeout_err    <= 1'b0;
            label_err      <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            cost_en    <= 1'b0;
            batch_done <= 1'b0;

            unique case (state)
                StIdle, StError: begin
                    if (start) begin
                        batch_total  <= '0;
                        batch_max    <= '0;
                        sample_count <= '0;
                        timeout_err  <= 1'b0;
                        label_err    <= 1'b0;
                        sample_ready <= 1'b1;
                        busy         <= 1'b1;
                        state        <= StWaitSample;
                    end
                end

                StWaitSample: begin
                    if (sample_valid) begin
                        expected_label <= label_in;
                        digit_weights  <= weights_in;
                        if (label_onehot) begin
                            sample_ready <= 1'b0;
                            cost_en      <= 1'b1;
                            state        <= StLaunch;
                        end else begin
                            // Reject and stay ready for the next offer.
                            label_err <= 1'b1;
                        end
                    end
                end

                StLaunch: begin
                    timer <= '0;
                    state <= StWaitCalc;
                end

                StWaitCalc: begin
                    timer <= timer + 1'b1;
                    if (calculation_complete) begin
                        // Completion takes priority over a coincident timeout.
                        cost_reg <= cost_output;
                        state    <= StAccum;
                    end else if (timer == TW'(TIMEOUT - 2)) begin
                        // The counter is about to reach TIMEOUT-1, so the error lands
                        // exactly TIMEOUT cycles after the launch pulse.
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= StError;
                    end
                end

                StAccum: begin
                    batch_total  <= sat_total;
                    sample_count <= next_count;
                    if (cost_reg > batch_max) begin
                        batch_max <= cost_reg;
                    end
                    if (next_count == 5'(BATCH_SIZE)) begin
                        batch_done <= 1'b1;
                        state      <= StDone;
                    end else begin
                        sample_ready <= 1'b1;
                        state        <= StWaitSample;
                    end
                end

                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end

                default: begin
                    sample_ready <= 1'b0;
                    busy         <= 1'b0;
                    state        <= StIdle;
                end
            endcase
        end
    end

endmodule
